// File: rtl/ui_pkg.sv
// Shared panel I/O constants: LED burst state encoding and timer sizing helper.
package ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_t;

    // Width of the ms timer. It is never narrower than 1 bit, so ON_MS=OFF_MS=1 still yields a usable vector.
    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/led_burst_gen.sv
// Turns a one-cycle trigger into a burst of count LED blinks timed in 1 kHz ticks,
// with busy/done status and a one-deep, overwrite-on-retrigger request queue.
module led_burst_gen
    import ui_pkg::*;
#(
    parameter int ON_MS  = 200,
    parameter int OFF_MS = 200,
    parameter int CNT_W  = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             KHz_enable,
    input  logic             trig,
    input  logic [CNT_W-1:0] count,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int            TW       = timer_w(ON_MS, OFF_MS);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_MS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_MS - 1);

    blink_state_t     r_state, w_state_nx;
    logic [TW-1:0]    r_timer, w_timer_nx;
    logic [CNT_W-1:0] r_remaining, w_remaining_nx;
    logic [CNT_W-1:0] r_pend_cnt, w_pend_cnt_nx;
    logic             r_pend_vld, w_pend_vld_nx;
    logic             w_done_nx;
    logic             w_req;

    assign w_req = trig && (count != '0);

    always_comb begin
        w_state_nx     = r_state;
        w_timer_nx     = r_timer;
        w_remaining_nx = r_remaining;
        w_pend_cnt_nx  = r_pend_cnt;
        w_pend_vld_nx  = r_pend_vld;
        w_done_nx      = 1'b0;

        // Capture first, so a request landing on the final OFF tick is chained immediately.
        if (r_state != ST_IDLE && w_req) begin
            w_pend_vld_nx = 1'b1;
            w_pend_cnt_nx = count;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nx     = ST_ON;
                    w_timer_nx     = '0;
                    w_remaining_nx = count;
                end
            end
            ST_ON: begin
                if (KHz_enable) begin
                    if (r_timer == ON_LAST) begin
                        w_timer_nx     = '0;
                        w_remaining_nx = (r_remaining != '0) ? r_remaining - 1'b1 : '0;
                        w_state_nx     = ST_OFF;
                    end else begin
                        w_timer_nx = r_timer + 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (KHz_enable) begin
                    if (r_timer == OFF_LAST) begin
                        w_timer_nx = '0;
                        if (r_remaining != '0) begin
                            w_state_nx = ST_ON;
                        end else begin
                            w_done_nx = 1'b1;
                            if (w_pend_vld_nx) begin
                                w_remaining_nx = w_pend_cnt_nx;
                                w_pend_vld_nx  = 1'b0;
                                w_pend_cnt_nx  = '0;
                                w_state_nx     = ST_ON;
                            end else begin
                                w_state_nx = ST_IDLE;
                            end
                        end
                    end else begin
                        w_timer_nx = r_timer + 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_remaining <= '0;
            r_pend_cnt  <= '0;
            r_pend_vld  <= 1'b0;
            led         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_timer     <= w_timer_nx;
            r_remaining <= w_remaining_nx;
            r_pend_cnt  <= w_pend_cnt_nx;
            r_pend_vld  <= w_pend_vld_nx;
            // Outputs follow the next state so they line up with the state register.
            led         <= (w_state_nx == ST_ON);
            busy        <= (w_state_nx != ST_IDLE);
            done        <= w_done_nx;
        end
    end

endmodule

// File: tb/tb_led_burst_gen.sv
// Directed bench for led_burst_gen with ON_MS=3, OFF_MS=2 and a tick every 4 clocks.
module tb_led_burst_gen;

    localparam int ON_MS  = 3;
    localparam int OFF_MS = 2;
    localparam int CNT_W  = 4;
    localparam int ON_MIN  = (ON_MS - 1) * 4 + 1;
    localparam int ON_MAX  = ON_MS * 4;
    localparam int OFF_MIN = (OFF_MS - 1) * 4 + 1;
    localparam int OFF_MAX = OFF_MS * 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             KHz_enable;
    logic             trig = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             led, busy, done;
    logic [1:0]       r_div = 2'd0;

    int checks = 0;
    int errors = 0;

    int o_falls, o_dones, o_falls_first_done, o_dones_busy, o_busy_falls;
    int o_on_min, o_on_max, o_off_min, o_off_max, o_led_hi, o_busy_hi;

    led_burst_gen #(.ON_MS(ON_MS), .OFF_MS(OFF_MS), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .KHz_enable(KHz_enable), .trig(trig),
        .count(count), .led(led), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) r_div <= r_div + 2'd1;
    assign KHz_enable = (r_div == 2'd3);

    // Collects blink statistics over a fixed window. init_run is the number of
    // led=1 cycles already seen for the current blink, or -1 when unknown.
    task automatic observe(input int ncyc, input int init_run);
        logic pl, pb;
        int run, offrun;
        o_falls = 0; o_dones = 0; o_falls_first_done = -1; o_dones_busy = 0;
        o_busy_falls = 0; o_on_min = 1000; o_on_max = 0; o_off_min = 1000;
        o_off_max = 0; o_led_hi = 0; o_busy_hi = 0;
        pl = led; pb = busy; run = init_run; offrun = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            if (led && !pl) begin
                run = 1;
                if (offrun > 0) begin
                    if (offrun < o_off_min) o_off_min = offrun;
                    if (offrun > o_off_max) o_off_max = offrun;
                end
                offrun = 0;
            end else if (led && run > 0) begin
                run++;
            end else if (!led && pl) begin
                o_falls++;
                if (run > 0) begin
                    if (run < o_on_min) o_on_min = run;
                    if (run > o_on_max) o_on_max = run;
                end
                run = 0;
                offrun = 1;
            end else if (!led && offrun > 0) begin
                offrun++;
            end
            if (done) begin
                o_dones++;
                if (o_dones == 1) o_falls_first_done = o_falls;
                if (busy) o_dones_busy++;
            end
            if (pb && !busy) o_busy_falls++;
            if (led) o_led_hi++;
            if (busy) o_busy_hi++;
            pl = led; pb = busy;
        end
    endtask

    task automatic fire(input logic [CNT_W-1:0] c);
        @(negedge CLK);
        trig = 1'b1; count = c;
        @(negedge CLK);
        trig = 1'b0; count = '0;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (led !== 1'b0)  begin errors++; $display("FAIL reset_led got %b want 0", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single;
        fire(4'd1);
        checks++; if (led !== 1'b1)  begin errors++; $display("FAIL single_led_latency got %b want 1", led); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b want 1", busy); end
        observe(40, 1);
        checks++; if (o_falls !== 1) begin errors++; $display("FAIL single_blinks got %0d want 1", o_falls); end
        checks++; if (o_dones !== 1) begin errors++; $display("FAIL single_done got %0d want 1", o_dones); end
        checks++; if (o_on_min < ON_MIN || o_on_max > ON_MAX)
            begin errors++; $display("FAIL single_on_time got %0d..%0d want %0d..%0d", o_on_min, o_on_max, ON_MIN, ON_MAX); end
        checks++; if (o_dones_busy !== 0) begin errors++; $display("FAIL single_busy_at_done got %0d want 0", o_dones_busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    endtask

    task automatic test_burst3;
        fire(4'd3);
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL burst3_led_latency got %b want 1", led); end
        observe(90, 1);
        checks++; if (o_falls !== 3) begin errors++; $display("FAIL burst3_blinks got %0d want 3", o_falls); end
        checks++; if (o_dones !== 1) begin errors++; $display("FAIL burst3_done got %0d want 1", o_dones); end
        checks++; if (o_on_min < ON_MIN || o_on_max > ON_MAX)
            begin errors++; $display("FAIL burst3_on_time got %0d..%0d want %0d..%0d", o_on_min, o_on_max, ON_MIN, ON_MAX); end
        checks++; if (o_off_min < OFF_MIN || o_off_max > OFF_MAX)
            begin errors++; $display("FAIL burst3_off_time got %0d..%0d want %0d..%0d", o_off_min, o_off_max, OFF_MIN, OFF_MAX); end
        checks++; if (o_busy_falls !== 1) begin errors++; $display("FAIL burst3_busy_falls got %0d want 1", o_busy_falls); end
    endtask

    task automatic test_zero;
        fire(4'd0);
        observe(40, -1);
        checks++; if (o_led_hi !== 0)  begin errors++; $display("FAIL zero_led got %0d want 0", o_led_hi); end
        checks++; if (o_busy_hi !== 0) begin errors++; $display("FAIL zero_busy got %0d want 0", o_busy_hi); end
        checks++; if (o_dones !== 0)   begin errors++; $display("FAIL zero_done got %0d want 0", o_dones); end
    endtask

    task automatic test_queue;
        fire(4'd2);
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL queue_led_latency got %b want 1", led); end
        @(negedge CLK);
        fire(4'd4);
        fire(4'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL queue_busy_early got %b want 1", busy); end
        observe(110, -1);
        checks++; if (o_falls !== 3) begin errors++; $display("FAIL queue_blinks got %0d want 3", o_falls); end
        checks++; if (o_dones !== 2) begin errors++; $display("FAIL queue_dones got %0d want 2", o_dones); end
        checks++; if (o_falls_first_done !== 2)
            begin errors++; $display("FAIL queue_first_done got %0d want 2", o_falls_first_done); end
        checks++; if (o_dones_busy !== 1) begin errors++; $display("FAIL queue_busy_at_done got %0d want 1", o_dones_busy); end
        checks++; if (o_busy_falls !== 1) begin errors++; $display("FAIL queue_busy_falls got %0d want 1", o_busy_falls); end
        checks++; if (o_on_min < ON_MIN || o_on_max > ON_MAX)
            begin errors++; $display("FAIL queue_on_time got %0d..%0d want %0d..%0d", o_on_min, o_on_max, ON_MIN, ON_MAX); end
    endtask

    task automatic test_boundary;
        int  offt;
        bit  found;
        bit  dropped;
        offt = -1; found = 1'b0; dropped = 1'b0;
        fire(4'd1);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge CLK);
            if (!busy) dropped = 1'b1;
            if (!led && busy) begin
                if (offt < 0) offt = 0;
                // KHz_enable here is what the next edge samples.
                if (KHz_enable) begin
                    if (offt == OFF_MS - 1) begin
                        trig = 1'b1; count = 4'd1; found = 1'b1;
                    end else begin
                        offt++;
                    end
                end
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL boundary_timeout got 0 want 1"); end
        @(negedge CLK);
        trig = 1'b0; count = '0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL boundary_done got %b want 1", done); end
        checks++; if (led !== 1'b1)  begin errors++; $display("FAIL boundary_led got %b want 1", led); end
        checks++; if (busy !== 1'b1 || dropped)
            begin errors++; $display("FAIL boundary_busy got %b dropped %0d want 1 dropped 0", busy, dropped); end
        observe(40, 1);
        checks++; if (o_falls !== 1) begin errors++; $display("FAIL boundary_blinks got %0d want 1", o_falls); end
        checks++; if (o_dones !== 1) begin errors++; $display("FAIL boundary_done2 got %0d want 1", o_dones); end
    endtask

    task automatic test_reset_mid;
        logic pl;
        int   rises;
        fire(4'd5);
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL rstmid_led_latency got %b want 1", led); end
        pl = led; rises = 1;
        for (int i = 0; i < 80 && rises < 2; i++) begin
            @(negedge CLK);
            if (led && !pl) rises++;
            pl = led;
        end
        checks++; if (rises !== 2) begin errors++; $display("FAIL rstmid_second_on got %0d want 2", rises); end
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        checks++; if (led !== 1'b0)  begin errors++; $display("FAIL rstmid_led got %b want 0", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
        observe(60, -1);
        checks++; if (o_led_hi !== 0 || o_busy_hi !== 0 || o_dones !== 0)
            begin errors++; $display("FAIL rstmid_quiet got led %0d busy %0d done %0d want 0 0 0", o_led_hi, o_busy_hi, o_dones); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst3;
        test_zero;
        test_queue;
        test_boundary;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
